// File: rtl/weight_pingpong_buf.sv
// Two-bank (ping-pong) float16 weight RAM with per-bank EMPTY/FILLING/FULL tracking.
// Optional define WEIGHT_BUF_WCOUNT_EN adds per-bank write counters and out-of-range read detection.
module weight_pingpong_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [LANES*DATA_WIDTH-1:0]   wr_data,
    input  logic                          wr_done,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-2:0]         rd_addr,
    input  logic                          rd_release,
    output logic [LANES*DATA_WIDTH-1:0]   rd_data,
    output logic                          rd_valid,
    output logic                          rd_bank,
    output logic                          rd_bank_ready,
    output logic [1:0]                    bank_full,
    output logic                          err_overwrite
`ifdef WEIGHT_BUF_WCOUNT_EN
    ,
    output logic [ADDR_WIDTH-1:0]         bank0_words,
    output logic [ADDR_WIDTH-1:0]         bank1_words,
    output logic                          rd_oob
`endif
);

    localparam int WORD_W = LANES * DATA_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    // FULL is encoded with bit 1 set so bank_full is taken straight off the state flops.
    localparam logic [1:0] ST_EMPTY   = 2'b00;
    localparam logic [1:0] ST_FILLING = 2'b01;
    localparam logic [1:0] ST_FULL    = 2'b10;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [1:0]        bank_st  [2];
    logic [1:0]        st_nxt   [2];
    logic              last_wr_bank;
    logic              wr_done_d;

    logic       wr_bank;
    logic       done_edge;
    logic       rd_fire;
    logic       rel_fire;
    logic [1:0] rel_i;
    logic [1:0] wr_ok;
    logic [1:0] close_i;
    logic       wr_accept;
    logic       wr_reject;

    assign wr_bank       = wr_addr[ADDR_WIDTH-1];
    assign done_edge     = wr_done & ~wr_done_d;
    assign bank_full     = {bank_st[1][1], bank_st[0][1]};
    assign rd_bank_ready = bank_full[rd_bank];
    assign rd_fire       = rd_en & rd_bank_ready;
    assign rel_fire      = rd_release & rd_bank_ready;

    // Release is applied before the write check, so a bank handed back this
    // cycle can accept a write on the same edge without flagging an error.
    always_comb begin
        rel_i   = '0;
        wr_ok   = '0;
        close_i = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            st_nxt[i]  = bank_st[i];
            rel_i[i]   = rel_fire && (rd_bank == 1'(i));
            close_i[i] = done_edge && (last_wr_bank == 1'(i)) && (bank_st[i] == ST_FILLING);
            wr_ok[i]   = wr_en && (wr_bank == 1'(i)) && (rel_i[i] || (bank_st[i] != ST_FULL));
            if (rel_i[i]) begin
                st_nxt[i] = wr_ok[i] ? ST_FILLING : ST_EMPTY;
            end else if (close_i[i]) begin
                st_nxt[i] = ST_FULL;
            end else if (wr_ok[i] && (bank_st[i] == ST_EMPTY)) begin
                st_nxt[i] = ST_FILLING;
            end
        end
        wr_accept = |wr_ok;
        wr_reject = wr_en & ~wr_accept;
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef WEIGHT_BUF_WCOUNT_EN
    logic [ADDR_WIDTH-1:0] wcnt [2];
    logic                  rd_is_oob;

    assign bank0_words = wcnt[0];
    assign bank1_words = wcnt[1];
    assign rd_is_oob   = ({1'b0, rd_addr} >= wcnt[rd_bank]);

    // Counters saturate rather than wrap when one address is rewritten many times.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt[0] <= '0;
            wcnt[1] <= '0;
            rd_oob  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (rel_i[i]) begin
                    wcnt[i] <= wr_ok[i] ? ADDR_WIDTH'(1) : '0;
                end else if (wr_ok[i] && (wcnt[i] != '1)) begin
                    wcnt[i] <= wcnt[i] + 1'b1;
                end
            end
            rd_oob <= rd_fire & rd_is_oob;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_st[0]    <= ST_EMPTY;
            bank_st[1]    <= ST_EMPTY;
            last_wr_bank  <= 1'b0;
            wr_done_d     <= 1'b0;
            rd_bank       <= 1'b0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            err_overwrite <= 1'b0;
        end else begin
            bank_st[0] <= st_nxt[0];
            bank_st[1] <= st_nxt[1];
            wr_done_d  <= wr_done;
            rd_valid   <= rd_fire;
            if (wr_accept) begin
                last_wr_bank <= wr_bank;
            end
            if (wr_reject) begin
                err_overwrite <= 1'b1;
            end
            if (rel_fire) begin
                rd_bank <= ~rd_bank;
            end
            if (rd_fire) begin
`ifdef WEIGHT_BUF_WCOUNT_EN
                rd_data <= rd_is_oob ? '0 : mem[{rd_bank, rd_addr}];
`else
                rd_data <= mem[{rd_bank, rd_addr}];
`endif
            end
        end
    end

endmodule

// File: doc/weight_pingpong_buf.md
Name: weight_pingpong_buf

Overview:
- Downstream consumer of the float16 weight transfer stage.
- Captures wide weight words and their write addresses into a two-bank (ping-pong) weight RAM; bank = address MSB (lower half / WEIGHT_RAM_HALF upper half).
- Tracks per-bank fill state so the conv engine reads one bank while the other is refilled; engine hands a bank back with a release pulse.

Parameters:
- DATA_WIDTH, 16, bits per float16 element.
- LANES, 8, elements per word (PARA_Y*PARA_KERNEL).
- ADDR_WIDTH, 10, write address width; MSB selects bank, depth per bank 2^(ADDR_WIDTH-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe for wr_data at wr_addr.
- wr_addr  in  ADDR_WIDTH  write address; bit ADDR_WIDTH-1 = bank.
- wr_data  in  LANES*DATA_WIDTH  packed weight word.
- wr_done  in  1  producer's transfer-done level; rising edge closes the bank last written.
- rd_en  in  1  read request on the current read bank.
- rd_addr  in  ADDR_WIDTH-1  offset within the read bank.
- rd_release  in  1  one-cycle pulse: consumer has finished with the read bank.
- rd_data  out  LANES*DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data valid this cycle.
- rd_bank  out  1  bank currently exposed for reading.
- rd_bank_ready  out  1  rd_bank is FULL.
- bank_full  out  2  per-bank FULL flags, bit i = bank i.
- err_overwrite  out  1  sticky: a write was attempted into a FULL bank.

Behaviour:
- Reset (async, rst=0), all outputs 0:
  - both banks EMPTY; rd_bank=0; last_wr_bank=0; wr_done_d=0; rd_data=0; rd_valid=0; err_overwrite=0.
  - RAM contents not cleared.
- Per-bank state machine: EMPTY -> FILLING -> FULL -> EMPTY.
  - EMPTY->FILLING: accepted wr_en to that bank.
  - FILLING->FULL: wr_done & ~wr_done_d, and the bank equals last_wr_bank.
  - FULL->EMPTY: rd_release while rd_bank_ready and rd_bank = that bank.
- Write side:
  - wr_en to an EMPTY/FILLING bank: RAM written the same edge; last_wr_bank <= wr_addr MSB.
  - wr_en to a FULL bank: write dropped, RAM unchanged, err_overwrite <= 1 (cleared only by reset).
- wr_done edge:
  - Detected from a registered copy (wr_done_d).
  - An edge while last_wr_bank is EMPTY (no writes yet) is ignored.
  - A held-high level causes no further transitions.
- Read side:
  - rd_en with rd_bank_ready: rd_data <= RAM[{rd_bank, rd_addr}], rd_valid <= 1 next cycle. Latency is 1 cycle, and back-to-back reads run at full rate.
  - rd_en without rd_bank_ready: ignored; rd_valid <= 0 and rd_data holds.
- Release:
  - rd_release with rd_bank_ready: the bank goes EMPTY and rd_bank toggles the same edge.
  - rd_release without rd_bank_ready: ignored.
- Simultaneous events:
  - rd_en and rd_release in the same cycle: the read is served from the old bank first.
  - A write to the bank being released in the same cycle: the release applies first, the write is accepted, and the bank ends FILLING with no error.
  - A wr_done edge and a write to the other bank in the same cycle: the edge closes the previous last_wr_bank.
- Outputs:
  - rd_bank_ready = bank_full[rd_bank], combinational from state registers.
  - bank_full is registered state.
- Reset mid-operation: any in-flight read is discarded (rd_valid=0), and state returns to the reset values.

Optional Feature:
- Macro: WEIGHT_BUF_WCOUNT_EN.
- Defined:
  - Adds outputs bank0_words and bank1_words (each ADDR_WIDTH bits). Each counts accepted writes since that bank was last EMPTY and resets to 0 on release.
  - A read with rd_addr >= the bank's count returns rd_data=0 with rd_valid=1, and pulses an added output rd_oob for 1 cycle.
- Undefined: no counters, no rd_oob; any in-range offset reads RAM directly.

Test Plan:
- Fill bank 0: write addrs 0..3 with data 0x0001..0x0004 in lane 0, then raise wr_done -> bank_full=2'b01, rd_bank_ready=1 one cycle after the edge. rd_en at addr 2 -> rd_valid the next cycle, rd_data lane 0 = 0x0003.
- Ping-pong:
  - With bank 0 FULL, write addr 512..515 and toggle wr_done low/high -> bank_full=2'b11.
  - rd_release -> rd_bank=1, bank_full=2'b10.
  - rd_en at addr 0 -> rd_data = word written at 512.
- Overwrite guard: with bank 0 FULL, wr_en at addr 1 with 0xFFFF in every lane -> err_overwrite=1 and stays 1. Reading addr 1 still returns the original data.
- Ignored requests from reset:
  - rd_en -> rd_valid=0.
  - rd_release -> rd_bank stays 0.
  - wr_done edge before any write -> bank_full stays 2'b00.
- Same-cycle release+write: bank 0 FULL and rd_bank=0; rd_release plus wr_en at addr 0 the same cycle -> bank 0 FILLING, rd_bank=1, err_overwrite=0.
- Reset mid-read: assert rst=0 the cycle after rd_en -> rd_valid=0 and bank_full=0 immediately (async), rd_bank=0.
